vme_cycle_ctrl: RTL and testbench

VME_CYCLE_CTRL -- requirements
Module: vme_cycle_ctrl

---
 rtl/vme_cycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_vme_cycle_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_cycle_ctrl.sv
// VME slave cycle controller: synchronizes the VME strobes, issues one local request per
// cycle and answers with DTACK* or BERR*, then enforces a quiet gap before the next cycle.
module vme_cycle_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       as_n,
    input  logic       ds0_n,
    input  logic       ds1_n,
    input  logic       write_n,
    input  logic       addr_match,
    input  logic       local_ack,
    input  logic       dtack_to_err,
    output logic       timer_start,
    output logic       local_rd,
    output logic       local_wr,
    output logic       dtack_n,
    output logic       berr_n,
    output logic       busy,
    output logic [7:0] to_count
);

    localparam int NSIG = 4;
    localparam int CW   = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_DTACK    = 3'd3,
        S_BERR     = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    logic [NSIG-1:0] raw_n;
    logic [NSIG-1:0] sync_n;
    logic            as_s;
    logic            ds_s;
    logic            wr_s;

    assign raw_n = {as_n, ds0_n, ds1_n, write_n};

    // One shift chain per asynchronous input; chains reset to the idle (high) level.
    genvar gi;
    generate
        for (gi = 0; gi < NSIG; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    chain_reg <= '1;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw_n[gi]};
                end
            end
            assign sync_n[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign as_s = ~sync_n[3];
    assign ds_s = ~sync_n[2] | ~sync_n[1];
    assign wr_s = ~sync_n[0];

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   rel_cnt_reg;
    logic            wr_lat_reg;
    logic            timer_start_reg;
    logic            local_rd_reg;
    logic            local_wr_reg;
    logic            dtack_n_reg;
    logic            berr_n_reg;
    logic            busy_reg;
    logic [7:0]      to_count_reg;

    // A master that drops DS while we wait has abandoned the cycle; that check comes first.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (as_s && ds_s && addr_match) state_next = S_REQ;
            S_REQ:      state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!ds_s)             state_next = S_RELEASE;
                else if (local_ack)    state_next = S_DTACK;
                else if (dtack_to_err) state_next = S_BERR;
            end
            S_DTACK:    if (!ds_s) state_next = S_RELEASE;
            S_BERR:     if (!ds_s) state_next = S_RELEASE;
            S_RELEASE:  if (!ds_s && rel_cnt_reg == REL_LAST) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Level outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            rel_cnt_reg     <= '0;
            wr_lat_reg      <= 1'b0;
            timer_start_reg <= 1'b0;
            local_rd_reg    <= 1'b0;
            local_wr_reg    <= 1'b0;
            dtack_n_reg     <= 1'b1;
            berr_n_reg      <= 1'b1;
            busy_reg        <= 1'b0;
            to_count_reg    <= 8'd0;
        end else begin
            state_reg <= state_next;

            if (state_reg == S_IDLE && state_next == S_REQ) begin
                wr_lat_reg <= wr_s;
            end

            // Quiet cycles must be consecutive with DS released.
            if (state_reg != S_RELEASE || ds_s) begin
                rel_cnt_reg <= '0;
            end else if (rel_cnt_reg != REL_LAST) begin
                rel_cnt_reg <= rel_cnt_reg + CW'(1);
            end

            local_rd_reg    <= (state_reg == S_REQ) && !wr_lat_reg;
            local_wr_reg    <= (state_reg == S_REQ) && wr_lat_reg;
            timer_start_reg <= (state_next == S_REQ) || (state_next == S_WAIT_ACK);
            dtack_n_reg     <= (state_next != S_DTACK);
            berr_n_reg      <= (state_next != S_BERR);
            busy_reg        <= (state_next != S_IDLE);

            if (state_reg == S_WAIT_ACK && state_next == S_BERR && to_count_reg != 8'hFF) begin
                to_count_reg <= to_count_reg + 8'd1;
            end
        end
    end

    assign timer_start = timer_start_reg;
    assign local_rd    = local_rd_reg;
    assign local_wr    = local_wr_reg;
    assign dtack_n     = dtack_n_reg;
    assign berr_n      = berr_n_reg;
    assign busy        = busy_reg;
    assign to_count    = to_count_reg;

endmodule

// File: tb/tb_vme_cycle_ctrl.sv
// Bench for vme_cycle_ctrl: table of VME cycles with a per-cycle scoreboard, plus
// hand-written sequences for address mismatch, reset during DTACK and counter saturation.
module tb_vme_cycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       as_n = 1'b1;
    logic       ds0_n = 1'b1;
    logic       ds1_n = 1'b1;
    logic       write_n = 1'b1;
    logic       addr_match = 1'b0;
    logic       local_ack = 1'b0;
    logic       dtack_to_err = 1'b0;
    logic       timer_start;
    logic       local_rd;
    logic       local_wr;
    logic       dtack_n;
    logic       berr_n;
    logic       busy;
    logic [7:0] to_count;

    // DS is captured at the first edge; the request is visible three edges later.
    localparam int LAT_NEGEDGES = 4;
    localparam int REL_CYCLES   = 2;

    vme_cycle_ctrl #(.SYNC_STAGES(2), .RELEASE_CYCLES(REL_CYCLES)) dut (
        .clk          (clk),
        .reset        (reset),
        .as_n         (as_n),
        .ds0_n        (ds0_n),
        .ds1_n        (ds1_n),
        .write_n      (write_n),
        .addr_match   (addr_match),
        .local_ack    (local_ack),
        .dtack_to_err (dtack_to_err),
        .timer_start  (timer_start),
        .local_rd     (local_rd),
        .local_wr     (local_wr),
        .dtack_n      (dtack_n),
        .berr_n       (berr_n),
        .busy         (busy),
        .to_count     (to_count)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic wr;
        logic use_ds1;
        int   ack_dly;
        int   to_dly;
        int   abort_dly;
        int   e_rd;
        int   e_wr;
        int   e_dt;
        int   e_be;
        int   to_inc;
    } vec_t;

    typedef struct {
        int   rd;
        int   wr;
        int   dt;
        int   be;
        int   to_cnt;
        logic check_tail;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_to = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: one transaction spans the cycles where busy is high.
    int m_rd, m_wr, m_tail;
    int m_dt, m_be, m_both, m_tsbad, m_tsseen;
    bit in_txn = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            in_txn = 1'b0;
        end else begin
            if (busy && !in_txn) begin
                in_txn = 1'b1;
                m_rd = 0; m_wr = 0; m_tail = 0;
                m_dt = 0; m_be = 0; m_both = 0; m_tsbad = 0; m_tsseen = 0;
            end
            if (in_txn) begin
                if (busy) begin
                    m_rd += int'(local_rd);
                    m_wr += int'(local_wr);
                    if (!dtack_n) m_dt = 1;
                    if (!berr_n) m_be = 1;
                    if (!dtack_n && !berr_n) m_both = 1;
                    if (timer_start && (!dtack_n || !berr_n)) m_tsbad = 1;
                    if (timer_start) m_tsseen = 1;
                    if (!dtack_n || !berr_n) m_tail = 0;
                    else if (m_dt != 0 || m_be != 0) m_tail++;
                end else begin
                    in_txn = 1'b0;
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_txn: got a busy period, expected none");
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("rd_pulses", m_rd, e.rd);
                        check("wr_pulses", m_wr, e.wr);
                        check("dtack_seen", m_dt, e.dt);
                        check("berr_seen", m_be, e.be);
                        check("to_count", int'(to_count), e.to_cnt);
                        check("dtack_berr_overlap", m_both, 0);
                        check("timer_during_response", m_tsbad, 0);
                        check("timer_started", m_tsseen, 1);
                        if (e.check_tail) check("release_cycles", m_tail, REL_CYCLES);
                    end
                end
            end
        end
    end

    task automatic release_strobes();
        as_n = 1'b1;
        ds0_n = 1'b1;
        ds1_n = 1'b1;
        write_n = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        int  n;
        int  kmax;
        bit  seen;
        @(negedge clk);
        write_n = ~v.wr;
        addr_match = 1'b1;
        as_n = 1'b0;
        if (v.use_ds1) ds1_n = 1'b0;
        else ds0_n = 1'b0;
        if (v.to_inc > 0 && exp_to < 255) exp_to++;
        sb_q.push_back('{v.e_rd, v.e_wr, v.e_dt, v.e_be, exp_to, (v.e_dt != 0 || v.e_be != 0)});
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (local_rd || local_wr) seen = 1'b1;
        end
        check("req_latency", n, LAT_NEGEDGES);
        addr_match = 1'b0;
        kmax = v.ack_dly;
        if (v.to_dly > kmax) kmax = v.to_dly;
        if (v.abort_dly > kmax) kmax = v.abort_dly;
        for (int k = 1; k <= kmax; k++) begin
            local_ack = (k == v.ack_dly);
            dtack_to_err = (k == v.to_dly);
            if (k == v.abort_dly) release_strobes();
            @(negedge clk);
        end
        local_ack = 1'b0;
        dtack_to_err = 1'b0;
        if (v.abort_dly == 0) begin
            n = 0;
            while (dtack_n && berr_n && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        release_strobes();
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("busy_release", int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    vec_t tbl[8];
    vec_t tov;

    initial begin
        int n;
        int busy_any;
        int req_any;

        //           wr  ds1 ack to ab  rd wr dt be inc
        tbl[0] = '{1'b0, 1'b0, 5, 0, 0, 1, 0, 1, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 2, 0, 0, 0, 1, 1, 0, 0};
        tbl[2] = '{1'b1, 1'b0, 0, 4, 0, 0, 1, 0, 1, 1};
        tbl[3] = '{1'b0, 1'b0, 4, 4, 0, 1, 0, 1, 0, 0};
        tbl[4] = '{1'b0, 1'b0, 8, 0, 2, 1, 0, 0, 0, 0};
        tbl[5] = '{1'b1, 1'b1, 1, 0, 0, 0, 1, 1, 0, 0};
        tbl[6] = '{1'b0, 1'b0, 6, 3, 0, 1, 0, 0, 1, 1};
        tbl[7] = '{1'b1, 1'b0, 0, 9, 1, 0, 1, 0, 0, 0};
        tov    = '{1'b1, 1'b0, 0, 1, 0, 0, 1, 0, 1, 1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_timer_start", int'(timer_start), 0);
        check("rst_local_rd", int'(local_rd), 0);
        check("rst_local_wr", int'(local_wr), 0);
        check("rst_dtack_n", int'(dtack_n), 1);
        check("rst_berr_n", int'(berr_n), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_to_count", int'(to_count), 0);

        // Strobes asserted for another board.
        as_n = 1'b0;
        ds0_n = 1'b0;
        addr_match = 1'b0;
        busy_any = 0;
        req_any = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) busy_any = 1;
            if (local_rd || local_wr) req_any = 1;
        end
        check("nomatch_busy", busy_any, 0);
        check("nomatch_request", req_any, 0);
        release_strobes();
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Reset while DTACK* is driven.
        @(negedge clk);
        write_n = 1'b1;
        addr_match = 1'b1;
        as_n = 1'b0;
        ds0_n = 1'b0;
        n = 0;
        while (!local_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstdt_req_latency", n, LAT_NEGEDGES);
        addr_match = 1'b0;
        local_ack = 1'b1;
        @(negedge clk);
        local_ack = 1'b0;
        check("rstdt_dtack_before", int'(dtack_n), 0);
        reset = 1'b1;
        @(negedge clk);
        check("rstdt_dtack_n", int'(dtack_n), 1);
        check("rstdt_berr_n", int'(berr_n), 1);
        check("rstdt_busy", int'(busy), 0);
        check("rstdt_to_count", int'(to_count), 0);
        @(negedge clk);
        reset = 1'b0;
        exp_to = 0;
        release_strobes();
        repeat (4) @(negedge clk);
        run_txn(tbl[0]);

        for (int i = 0; i < 256; i++) run_txn(tov);
        check("to_count_saturated", int'(to_count), 255);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
